// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared widths, FSM states and channel encoding for the memory access unit
package mem_access_unit_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH_LOG2 = 8;
  localparam int WORD_BYTES = 4;
  localparam int RANGE_LSB = DEPTH_LOG2 + $clog2(WORD_BYTES);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, STORE, REJECT, RESP} state_t;
  typedef enum logic {CH_FETCH, CH_DATA} ch_t;
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: core request/response handshake plus unified-memory port bundle; slave = unit side, master = core/memory side
interface mem_access_unit_if #(
  parameter int ADDR_W = mem_access_unit_pkg::ADDR_W,
  parameter int DATA_W = mem_access_unit_pkg::DATA_W
);
  logic ready;
  logic if_req;
  logic [ADDR_W-1:0] if_addr;
  logic ls_req;
  logic ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic if_valid;
  logic [DATA_W-1:0] if_inst;
  logic ls_done;
  logic [DATA_W-1:0] ls_rdata;
  logic err;
  logic [ADDR_W-1:0] mem_pc;
  logic [DATA_W-1:0] mem_inst;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;
  logic mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  modport slave (
    input if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_inst, mem_rdata,
    output ready, if_valid, if_inst, ls_done, ls_rdata, err,
    output mem_pc, mem_raddr, mem_we, mem_waddr, mem_wdata
  );
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_inst, mem_rdata,
    input ready, if_valid, if_inst, ls_done, ls_rdata, err,
    input mem_pc, mem_raddr, mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit_addr_check.sv
// mem_addr_check: combinational word-alignment and range check of a byte address (addr -> misaligned, out_of_range)
module mem_addr_check
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = mem_access_unit_pkg::ADDR_W,
  parameter int HI_LSB = RANGE_LSB
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              misaligned,
  output logic              out_of_range
);
  assign misaligned = |addr[$clog2(WORD_BYTES)-1:0];
  assign out_of_range = |addr[ADDR_W-1:HI_LSB];
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: fetch/load/store initiator to unified memory; clk, rst (async high), bus = handshake + memory ports
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DEPTH_LOG2_P = DEPTH_LOG2
) (
  input logic clk,
  input logic rst,
  mem_access_unit_if.slave bus
);
  state_t state, next_state;
  ch_t ch;
  logic rej;
  logic if_mis, if_oor, ls_mis, ls_oor, if_bad, ls_bad, take;
  mem_addr_check #(.ADDR_W(ADDR_W), .HI_LSB(DEPTH_LOG2_P + $clog2(WORD_BYTES))) u_if_chk (
    .addr(bus.if_addr), .misaligned(if_mis), .out_of_range(if_oor)
  );
  mem_addr_check #(.ADDR_W(ADDR_W), .HI_LSB(DEPTH_LOG2_P + $clog2(WORD_BYTES))) u_ls_chk (
    .addr(bus.ls_addr), .misaligned(ls_mis), .out_of_range(ls_oor)
  );
  assign if_bad = if_mis | if_oor;
  assign ls_bad = ls_mis | ls_oor;
  assign take = (state == IDLE) && (bus.ls_req || bus.if_req);
  // load/store wins over a simultaneous fetch: it belongs to the older instruction
  always_comb begin
    next_state = IDLE;
    if (state == IDLE)
      next_state = bus.ls_req ? (ls_bad ? REJECT : bus.ls_we ? STORE : LOAD)
                 : bus.if_req ? (if_bad ? REJECT : FETCH) : IDLE;
    else if (state != RESP)
      next_state = RESP;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next_state;
  // memory port registers load at acceptance so they are valid during the access cycle and hold afterwards
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ch <= CH_FETCH;
      rej <= 1'b0;
      bus.mem_pc <= '0;
      bus.mem_raddr <= '0;
      bus.mem_waddr <= '0;
      bus.mem_wdata <= '0;
      bus.if_inst <= '0;
      bus.ls_rdata <= '0;
    end else begin
      if (take) begin
        ch <= bus.ls_req ? CH_DATA : CH_FETCH;
        rej <= bus.ls_req ? ls_bad : if_bad;
      end
      if (next_state == FETCH) bus.mem_pc <= bus.if_addr;
      if (next_state == LOAD) bus.mem_raddr <= bus.ls_addr;
      if (next_state == STORE) begin
        bus.mem_waddr <= bus.ls_addr;
        bus.mem_wdata <= bus.ls_wdata;
      end
      if (state == FETCH) bus.if_inst <= bus.mem_inst;
      if (state == LOAD) bus.ls_rdata <= bus.mem_rdata;
    end
  // decoded from state so an asynchronous reset drops mem_we before the write edge
  assign bus.ready = state == IDLE;
  assign bus.mem_we = state == STORE;
  assign bus.if_valid = (state == RESP) && (ch == CH_FETCH);
  assign bus.ls_done = (state == RESP) && (ch == CH_DATA);
  assign bus.err = (state == RESP) && rej;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit with a 256-word behavioural memory
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [31:0] mem [256];
  logic tb_we = 1'b0;
  logic [7:0] tb_a = '0;
  logic [31:0] tb_d = '0;
  mem_access_unit_if bus ();
  mem_access_unit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.mem_inst = mem[bus.mem_pc[9:2]];
  assign bus.mem_rdata = mem[bus.mem_raddr[9:2]];
  always @(posedge clk)
    if (bus.mem_we) mem[bus.mem_waddr[9:2]] <= bus.mem_wdata;
    else if (tb_we) mem[tb_a] <= tb_d;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    tb_we = 1'b1; tb_a = a; tb_d = d;
    tick();
    tb_we = 1'b0;
  endtask
  task automatic idle_inputs();
    bus.if_req = 1'b0; bus.if_addr = '0; bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0; bus.ls_wdata = '0;
  endtask
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    tests++; if (bus.ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", bus.ready); end
    tests++; if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we got %b want 0", bus.mem_we); end
    tests++; if ({bus.if_valid, bus.ls_done, bus.err} !== 3'b000) begin fails++; $display("FAIL reset_pulses got %b want 000", {bus.if_valid, bus.ls_done, bus.err}); end
    tests++; if ({bus.mem_pc, bus.mem_raddr, bus.mem_waddr, bus.mem_wdata, bus.if_inst, bus.ls_rdata} !== '0) begin fails++; $display("FAIL reset_regs got nonzero pc=%h ra=%h wa=%h", bus.mem_pc, bus.mem_raddr, bus.mem_waddr); end
    rst = 1'b0;
    tick();
  endtask
  task automatic test_fetch();
    poke(8'd2, 32'h1234_5678);
    bus.if_req = 1'b1; bus.if_addr = 32'h8;
    tick();
    bus.if_req = 1'b0;
    tests++; if (bus.ready !== 1'b0) begin fails++; $display("FAIL fetch_busy1 ready got %b want 0", bus.ready); end
    tests++; if (bus.mem_pc !== 32'h8) begin fails++; $display("FAIL fetch_pc got %h want 00000008", bus.mem_pc); end
    tests++; if (bus.if_valid !== 1'b0) begin fails++; $display("FAIL fetch_early_valid got %b want 0", bus.if_valid); end
    tick();
    tests++; if (bus.ready !== 1'b0) begin fails++; $display("FAIL fetch_busy2 ready got %b want 0", bus.ready); end
    tests++; if ({bus.if_valid, bus.err, bus.ls_done} !== 3'b100) begin fails++; $display("FAIL fetch_resp got %b want 100", {bus.if_valid, bus.err, bus.ls_done}); end
    tests++; if (bus.if_inst !== 32'h1234_5678) begin fails++; $display("FAIL fetch_inst got %h want 12345678", bus.if_inst); end
    tick();
    tests++; if ({bus.ready, bus.if_valid} !== 2'b10) begin fails++; $display("FAIL fetch_done got %b want 10", {bus.ready, bus.if_valid}); end
  endtask
  task automatic test_store_load();
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'h10; bus.ls_wdata = 32'hDEAD_BEEF;
    tick();
    bus.ls_req = 1'b0; bus.ls_we = 1'b0;
    tests++; if ({bus.mem_we, bus.mem_waddr, bus.mem_wdata} !== {1'b1, 32'h10, 32'hDEAD_BEEF}) begin fails++; $display("FAIL store_port got we=%b a=%h d=%h want 1 00000010 deadbeef", bus.mem_we, bus.mem_waddr, bus.mem_wdata); end
    tick();
    tests++; if ({bus.mem_we, bus.ls_done, bus.err} !== 3'b010) begin fails++; $display("FAIL store_resp got %b want 010", {bus.mem_we, bus.ls_done, bus.err}); end
    tests++; if (mem[4] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL store_commit got %h want deadbeef", mem[4]); end
    tick();
    bus.ls_req = 1'b1; bus.ls_addr = 32'h10;
    tick();
    bus.ls_req = 1'b0;
    tests++; if ({bus.mem_we, bus.mem_raddr} !== {1'b0, 32'h10}) begin fails++; $display("FAIL load_port got we=%b a=%h want 0 00000010", bus.mem_we, bus.mem_raddr); end
    tick();
    tests++; if ({bus.ls_done, bus.err, bus.ls_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin fails++; $display("FAIL load_resp got %b %b %h want 1 0 deadbeef", bus.ls_done, bus.err, bus.ls_rdata); end
    tick();
  endtask
  task automatic test_priority();
    poke(8'd1, 32'hCAFE_F00D);
    poke(8'd3, 32'h0BAD_C0DE);
    bus.if_req = 1'b1; bus.if_addr = 32'hC; bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h4;
    tick();
    bus.ls_req = 1'b0;
    tests++; if ({bus.ready, bus.mem_raddr} !== {1'b0, 32'h4}) begin fails++; $display("FAIL prio_load_first got %b %h want 0 00000004", bus.ready, bus.mem_raddr); end
    tick();
    tests++; if ({bus.ls_done, bus.if_valid, bus.ls_rdata} !== {2'b10, 32'hCAFE_F00D}) begin fails++; $display("FAIL prio_load_resp got %b %b %h want 1 0 cafef00d", bus.ls_done, bus.if_valid, bus.ls_rdata); end
    tick();
    tests++; if ({bus.ready, bus.ls_done, bus.if_valid} !== 3'b100) begin fails++; $display("FAIL prio_gap got %b want 100", {bus.ready, bus.ls_done, bus.if_valid}); end
    tick();
    bus.if_req = 1'b0;
    tests++; if ({bus.ready, bus.mem_pc} !== {1'b0, 32'hC}) begin fails++; $display("FAIL prio_fetch_accept got %b %h want 0 0000000c", bus.ready, bus.mem_pc); end
    tick();
    tests++; if ({bus.if_valid, bus.if_inst} !== {1'b1, 32'h0BAD_C0DE}) begin fails++; $display("FAIL prio_fetch_resp got %b %h want 1 0badc0de", bus.if_valid, bus.if_inst); end
    tick();
  endtask
  task automatic test_reject();
    int we_seen = 0;
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'h6; bus.ls_wdata = 32'h1111_1111;
    tick();
    bus.ls_req = 1'b0; bus.ls_we = 1'b0;
    we_seen += int'(bus.mem_we);
    tick();
    we_seen += int'(bus.mem_we);
    tests++; if ({bus.ls_done, bus.err} !== 2'b11) begin fails++; $display("FAIL misaligned_resp got %b want 11", {bus.ls_done, bus.err}); end
    tests++; if (we_seen != 0) begin fails++; $display("FAIL misaligned_we got %0d cycles want 0", we_seen); end
    tests++; if (mem[1] !== 32'hCAFE_F00D) begin fails++; $display("FAIL misaligned_mem got %h want cafef00d", mem[1]); end
    tick();
    bus.ls_req = 1'b1; bus.ls_addr = 32'h400;
    tick();
    bus.ls_req = 1'b0;
    tests++; if (bus.mem_raddr !== 32'h4) begin fails++; $display("FAIL oor_raddr got %h want 00000004", bus.mem_raddr); end
    tick();
    tests++; if ({bus.ls_done, bus.err, bus.ls_rdata} !== {2'b11, 32'hCAFE_F00D}) begin fails++; $display("FAIL oor_resp got %b %b %h want 1 1 cafef00d", bus.ls_done, bus.err, bus.ls_rdata); end
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h2;
    tick();
    bus.if_req = 1'b0;
    tick();
    tests++; if ({bus.if_valid, bus.err, bus.if_inst} !== {2'b11, 32'h0BAD_C0DE}) begin fails++; $display("FAIL fetch_reject got %b %b %h want 1 1 0badc0de", bus.if_valid, bus.err, bus.if_inst); end
    tick();
  endtask
  task automatic test_reset_abort();
    poke(8'd8, 32'h5555_5555);
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'h20; bus.ls_wdata = 32'hAAAA_AAAA;
    tick();
    bus.ls_req = 1'b0; bus.ls_we = 1'b0;
    tests++; if (bus.mem_we !== 1'b1) begin fails++; $display("FAIL abort_we_before got %b want 1", bus.mem_we); end
    rst = 1'b1;
    #1;
    tests++; if ({bus.mem_we, bus.ready, bus.mem_waddr, bus.ls_rdata} !== {2'b01, 64'h0}) begin fails++; $display("FAIL abort_async got we=%b rdy=%b wa=%h rd=%h", bus.mem_we, bus.ready, bus.mem_waddr, bus.ls_rdata); end
    tick();
    rst = 1'b0;
    tests++; if (mem[8] !== 32'h5555_5555) begin fails++; $display("FAIL abort_no_commit got %h want 55555555", mem[8]); end
    tests++; if ({bus.ls_done, bus.err, bus.if_valid, bus.if_inst} !== 35'h0) begin fails++; $display("FAIL abort_outputs got %b %b %b %h want zeros", bus.ls_done, bus.err, bus.if_valid, bus.if_inst); end
    tick();
    tests++; if ({bus.ls_done, bus.ready} !== 2'b01) begin fails++; $display("FAIL abort_no_done got %b want 01", {bus.ls_done, bus.ready}); end
    bus.ls_req = 1'b1; bus.ls_addr = 32'h20;
    tick();
    bus.ls_req = 1'b0;
    tick();
    tests++; if ({bus.ls_done, bus.ls_rdata} !== {1'b1, 32'h5555_5555}) begin fails++; $display("FAIL abort_readback got %b %h want 1 55555555", bus.ls_done, bus.ls_rdata); end
    tick();
  endtask
  initial begin
    test_reset();
    test_fetch();
    test_store_load();
    test_priority();
    test_reject();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
